// File: rtl/bg_fill_engine.sv
// bg_fill_engine
//
// Writes a clipped rectangle into the vga_adapter framebuffer at one pixel
// per clock. The rectangle is filled with a solid colour, a checkerboard,
// horizontal bars or vertical bars.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 request a fill (only looked at while idle)
//   mode                  0 solid, 1 checker, 2 horizontal bars, 3 vertical bars
//   colour_a, colour_b    primary / secondary colour
//   x0, x1, y0, y1        inclusive rectangle bounds (x1/y1 clipped to screen)
//   x, y, colour, plot    registered pixel write to the adapter
//   busy                  high while pixels are being emitted
//   done                  one-cycle pulse after the last pixel (or empty rect)
module bg_fill_engine #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 3,
  parameter int CELL_LOG2   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [COLOUR_BITS-1:0] colour_a,
  input  logic [COLOUR_BITS-1:0] colour_b,
  input  logic [X_BITS-1:0]      x0,
  input  logic [X_BITS-1:0]      x1,
  input  logic [Y_BITS-1:0]      y0,
  input  logic [Y_BITS-1:0]      y1,
  output logic [X_BITS-1:0]      x,
  output logic [Y_BITS-1:0]      y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_BITS-1:0] X_MAX     = X_BITS'(H_RES - 1);
  localparam logic [Y_BITS-1:0] Y_MAX     = Y_BITS'(V_RES - 1);
  localparam logic [X_BITS:0]   H_RES_EXT = (X_BITS + 1)'(H_RES);
  localparam logic [Y_BITS:0]   V_RES_EXT = (Y_BITS + 1)'(V_RES);

  // Pattern phase comes from absolute screen coordinates so neighbouring
  // fills line up without seams.
  function automatic logic [COLOUR_BITS-1:0] pattern_colour(
    input logic [1:0]             m,
    input logic [COLOUR_BITS-1:0] ca,
    input logic [COLOUR_BITS-1:0] cb,
    input logic [X_BITS-1:0]      px,
    input logic [Y_BITS-1:0]      py
  );
    logic [COLOUR_BITS-1:0] c;
    case (m)
      2'd0:    c = ca;
      2'd1:    c = (px[CELL_LOG2] ^ py[CELL_LOG2]) ? cb : ca;
      2'd2:    c = py[CELL_LOG2] ? cb : ca;
      default: c = px[CELL_LOG2] ? cb : ca;
    endcase
    return c;
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [COLOUR_BITS-1:0] ca_q, ca_d;
  logic [COLOUR_BITS-1:0] cb_q, cb_d;
  logic [X_BITS-1:0]      x0_q, x0_d;
  logic [X_BITS-1:0]      x1_q, x1_d;
  logic [Y_BITS-1:0]      y1_q, y1_d;
  logic [X_BITS-1:0]      x_q, x_d;
  logic [Y_BITS-1:0]      y_q, y_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic                   plot_q, plot_d;

  logic [X_BITS-1:0] x1_clip;
  logic [Y_BITS-1:0] y1_clip;
  logic              rect_empty;

  always_comb begin
    x1_clip    = (x1 > X_MAX) ? X_MAX : x1;
    y1_clip    = (y1 > Y_MAX) ? Y_MAX : y1;
    rect_empty = (x0 > x1_clip) || (y0 > y1_clip) ||
                 ({1'b0, x0} >= H_RES_EXT) || ({1'b0, y0} >= V_RES_EXT);
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          ca_d   = colour_a;
          cb_d   = colour_b;
          x0_d   = x0;
          x1_d   = x1_clip;
          y1_d   = y1_clip;
          if (rect_empty) begin
            state_d = DONE;
          end else begin
            // First pixel is registered on the accepting edge.
            state_d  = DRAW;
            x_d      = x0;
            y_d      = y0;
            plot_d   = 1'b1;
            colour_d = pattern_colour(mode, colour_a, colour_b, x0, y0);
          end
        end
      end

      DRAW: begin
        // Compare against the bound before incrementing so the counters
        // never need to wrap past their full width.
        if (x_q == x1_q) begin
          if (y_q == y1_q) begin
            state_d = DONE;
          end else begin
            x_d    = x0_q;
            y_d    = y_q + 1'b1;
            plot_d = 1'b1;
          end
        end else begin
          x_d    = x_q + 1'b1;
          plot_d = 1'b1;
        end
        if (plot_d) begin
          colour_d = pattern_colour(mode_q, ca_q, cb_q, x_d, y_d);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      ca_q     <= '0;
      cb_q     <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = (state_q == DRAW);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_bg_fill_engine.sv
// Self-checking bench for bg_fill_engine: each scenario task drives a fill,
// records every cycle's outputs and compares against a reference model that
// enumerates the expected pixel list with plain arithmetic.
module tb_bg_fill_engine;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int XB = 8;
  localparam int YB = 7;
  localparam int CB = 3;
  localparam int CL = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [CB-1:0] colour_a, colour_b;
  logic [XB-1:0] x0, x1;
  logic [YB-1:0] y0, y1;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [CB-1:0] colour;
  logic          plot, busy, done;

  bg_fill_engine #(
    .H_RES(H), .V_RES(V), .X_BITS(XB), .Y_BITS(YB),
    .COLOUR_BITS(CB), .CELL_LOG2(CL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .colour_a(colour_a), .colour_b(colour_b),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int px;
    int py;
    int pc;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs_q[$];

  // Reference colour: cell index is coordinate divided by the cell size.
  function automatic int ref_colour(input int m, input int a, input int b,
                                    input int px, input int py);
    int cx;
    int cy;
    cx = (px / (1 << CL)) % 2;
    cy = (py / (1 << CL)) % 2;
    case (m)
      0:       return a;
      1:       return ((cx + cy) % 2 == 0) ? a : b;
      2:       return (cy == 0) ? a : b;
      default: return (cx == 0) ? a : b;
    endcase
  endfunction

  task automatic build_expected(input int m, input int a, input int b,
                                input int lx0, input int lx1,
                                input int ly0, input int ly1);
    int xe;
    int ye;
    pix_t p;
    exp_q.delete();
    xe = (lx1 < H - 1) ? lx1 : H - 1;
    ye = (ly1 < V - 1) ? ly1 : V - 1;
    if (lx0 > xe || ly0 > ye || lx0 >= H || ly0 >= V) return;
    for (int yy = ly0; yy <= ye; yy++) begin
      for (int xx = lx0; xx <= xe; xx++) begin
        p.px = xx;
        p.py = yy;
        p.pc = ref_colour(m, a, b, xx, yy);
        exp_q.push_back(p);
      end
    end
  endtask

  function automatic int find_obs(input int px, input int py);
    foreach (obs_q[i]) begin
      if (obs_q[i].px == px && obs_q[i].py == py) return obs_q[i].pc;
    end
    return -1;
  endfunction

  // Drive one fill and watch N+3 cycles after the accepting edge.
  // disturb: on cycle 3 re-pulse start and change colour_a/mode/bounds.
  task automatic run_fill(input int m, input int a, input int b,
                          input int lx0, input int lx1,
                          input int ly0, input int ly1,
                          input bit disturb, input string name);
    int n;
    int done_cnt;
    int done_cyc;
    int busy_err;
    int pix_err;
    int first_bad;
    pix_t p;
    build_expected(m, a, b, lx0, lx1, ly0, ly1);
    n = exp_q.size();
    obs_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_err = 0;
    pix_err = 0;
    first_bad = -1;

    @(negedge clock);
    mode     = 2'(m);
    colour_a = CB'(a);
    colour_b = CB'(b);
    x0       = XB'(lx0);
    x1       = XB'(lx1);
    y0       = YB'(ly0);
    y1       = YB'(ly1);
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= n + 3; k++) begin
      if (plot === 1'b1) begin
        p.px = int'(x);
        p.py = int'(y);
        p.pc = int'(colour);
        obs_q.push_back(p);
      end
      if (busy !== plot) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      if (disturb && k == 3) begin
        start    = 1'b1;
        colour_a = ~CB'(a);
        mode     = 2'(m) ^ 2'd1;
        x0       = '0;
        y0       = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;

    foreach (obs_q[i]) begin
      if (i < n) begin
        if (obs_q[i].px != exp_q[i].px || obs_q[i].py != exp_q[i].py ||
            obs_q[i].pc != exp_q[i].pc) begin
          pix_err++;
          if (first_bad < 0) first_bad = i;
        end
      end
    end

    tests_run++;
    if (obs_q.size() !== n) begin
      tests_failed++;
      $display("FAIL %s plot_count: got %0d expected %0d", name, obs_q.size(), n);
    end
    tests_run++;
    if (pix_err !== 0) begin
      tests_failed++;
      $display("FAIL %s pixels: %0d wrong, first #%0d got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
               name, pix_err, first_bad, obs_q[first_bad].px, obs_q[first_bad].py,
               obs_q[first_bad].pc, exp_q[first_bad].px, exp_q[first_bad].py,
               exp_q[first_bad].pc);
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== n + 1) begin
      tests_failed++;
      $display("FAIL %s done: got %0d pulses last at cycle %0d expected 1 pulse at cycle %0d",
               name, done_cnt, done_cyc, n + 1);
    end
    tests_run++;
    if (busy_err !== 0) begin
      tests_failed++;
      $display("FAIL %s busy_vs_plot: got %0d cycles busy!=plot expected 0", name, busy_err);
    end
    $display("[TB] fill %s: mode=%0d (%0d,%0d)-(%0d,%0d) plots=%0d expected=%0d",
             name, m, lx0, ly0, lx1, ly1, obs_q.size(), n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mode = '0;
    colour_a = '0;
    colour_b = '0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if ({x, y, colour, plot, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b expected all 0",
               x, y, colour, plot, busy, done);
    end
    $display("[TB] reset: x=%0d y=%0d colour=%0d plot=%b busy=%b done=%b",
             x, y, colour, plot, busy, done);
  endtask

  task automatic test_solid();
    int fx, fy, lx, ly;
    run_fill(0, 4, 0, 0, 159, 0, 119, 1'b0, "solid_full");
    fx = obs_q.size() > 0 ? obs_q[0].px : -1;
    fy = obs_q.size() > 0 ? obs_q[0].py : -1;
    lx = obs_q.size() > 0 ? obs_q[obs_q.size()-1].px : -1;
    ly = obs_q.size() > 0 ? obs_q[obs_q.size()-1].py : -1;
    tests_run++;
    if (fx !== 0 || fy !== 0 || lx !== 159 || ly !== 119) begin
      tests_failed++;
      $display("FAIL solid_corners: got first (%0d,%0d) last (%0d,%0d) expected (0,0) (159,119)",
               fx, fy, lx, ly);
    end
  endtask

  task automatic test_checker();
    int c77, c87, c88, wraps;
    run_fill(1, 0, 7, 6, 9, 6, 9, 1'b0, "checker");
    c77 = find_obs(7, 7);
    c87 = find_obs(8, 7);
    c88 = find_obs(8, 8);
    tests_run++;
    if (c77 !== 0 || c87 !== 7 || c88 !== 0) begin
      tests_failed++;
      $display("FAIL checker_points: got (7,7)=%0d (8,7)=%0d (8,8)=%0d expected 0 7 0",
               c77, c87, c88);
    end
    wraps = 0;
    for (int i = 1; i < obs_q.size(); i++) begin
      if (obs_q[i-1].px == 9 && obs_q[i].px == 6 && obs_q[i].py == obs_q[i-1].py + 1)
        wraps++;
    end
    tests_run++;
    if (wraps !== 3) begin
      tests_failed++;
      $display("FAIL checker_wraps: got %0d row wraps expected 3", wraps);
    end
  endtask

  task automatic test_clip();
    int max_x, max_y;
    run_fill(3, 2, 5, 150, 255, 115, 127, 1'b0, "clip");
    max_x = 0;
    max_y = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].px > max_x) max_x = obs_q[i].px;
      if (obs_q[i].py > max_y) max_y = obs_q[i].py;
    end
    tests_run++;
    if (max_x !== 159 || max_y !== 119) begin
      tests_failed++;
      $display("FAIL clip_bounds: got max x=%0d y=%0d expected 159 119", max_x, max_y);
    end
  endtask

  task automatic test_empty();
    run_fill(0, 5, 0, 20, 10, 0, 5, 1'b0, "empty_x");
    run_fill(2, 1, 6, 165, 200, 0, 3, 1'b0, "empty_offscreen");
  endtask

  task automatic test_ignore_start();
    run_fill(2, 1, 6, 10, 40, 20, 30, 1'b1, "ignore_start");
  endtask

  task automatic test_reset_abort();
    int plot_seen, busy_seen, done_seen, plot5;
    @(negedge clock);
    mode = 2'd0; colour_a = 3'd2; colour_b = 3'd0;
    x0 = 8'd0; x1 = 8'd50; y0 = 7'd0; y1 = 7'd10;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // Now in plot cycle 1; advance to plot cycle 5.
    for (int k = 1; k < 5; k++) @(negedge clock);
    plot5 = int'(plot);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    plot_seen = 0; busy_seen = 0; done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (plot !== 1'b0) plot_seen++;
      if (busy !== 1'b0) busy_seen++;
      if (done !== 1'b0) done_seen++;
      @(negedge clock);
    end
    tests_run++;
    if (plot5 !== 1 || plot_seen !== 0 || busy_seen !== 0 || done_seen !== 0) begin
      tests_failed++;
      $display("FAIL reset_abort: got plot@5=%0d plot=%0d busy=%0d done=%0d cycles expected 1 0 0 0",
               plot5, plot_seen, busy_seen, done_seen);
    end
    $display("[TB] reset_abort: plot@5=%0d plot=%0d busy=%0d done=%0d",
             plot5, plot_seen, busy_seen, done_seen);
    run_fill(3, 7, 1, 3, 20, 2, 6, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int m, a, b, lx0, lx1, ly0, ly1;
    for (int i = 0; i < 25; i++) begin
      m   = int'($urandom_range(0, 3));
      a   = int'($urandom_range(0, 7));
      b   = int'($urandom_range(0, 7));
      lx0 = int'($urandom_range(0, 170));
      lx1 = lx0 + int'($urandom_range(0, 24)) - 3;
      if (lx1 < 0) lx1 = 0;
      if (lx1 > 255) lx1 = 255;
      ly0 = int'($urandom_range(0, 125));
      ly1 = ly0 + int'($urandom_range(0, 12)) - 2;
      if (ly1 < 0) ly1 = 0;
      if (ly1 > 127) ly1 = 127;
      run_fill(m, a, b, lx0, lx1, ly0, ly1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_checker();
    test_clip();
    test_empty();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bg_fill_engine.md
# bg_fill_engine

Parametrised raster fill engine that writes rectangular regions into the vga_adapter framebuffer, one pixel per clock. It replaces fixed power-on background images with run-time backgrounds and patterns: solid fill, checkerboard, horizontal bars and vertical bars over any clipped rectangle. It sits between the top-level control (switches/FSM) and the vga_adapter `x`/`y`/`colour`/`plot` inputs.

## Interface

Parameters:
- `H_RES`, 160, horizontal resolution in pixels
- `V_RES`, 120, vertical resolution in pixels
- `X_BITS`, 8, width of x coordinates; must satisfy 2^X_BITS >= H_RES
- `Y_BITS`, 7, width of y coordinates; must satisfy 2^Y_BITS >= V_RES
- `COLOUR_BITS`, 3, colour width; 3 for 1 bit per channel
- `CELL_LOG2`, 3, log2 of pattern cell size in pixels; 3 gives 8x8 checker cells and 8-pixel bars

Ports:
- `clock`  in  1  system clock (CLOCK_50 at top level)
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a fill; sampled only in IDLE
- `mode`  in  2  fill mode: 0 solid, 1 checker, 2 horizontal bars, 3 vertical bars
- `colour_a`  in  COLOUR_BITS  primary colour
- `colour_b`  in  COLOUR_BITS  secondary colour; unused in mode 0
- `x0`, `x1`  in  X_BITS  inclusive left and right bounds
- `y0`, `y1`  in  Y_BITS  inclusive top and bottom bounds
- `x`  out  X_BITS  pixel x to the adapter
- `y`  out  Y_BITS  pixel y to the adapter
- `colour`  out  COLOUR_BITS  pixel colour to the adapter
- `plot`  out  1  write enable to the adapter
- `busy`  out  1  high while in DRAW
- `done`  out  1  one-cycle completion pulse

## Operation

- FSM states:
  - IDLE: `busy`=0, `plot`=0. `start`=1 latches `mode`, `colour_a`, `colour_b` and the clipped bounds. Next state is DRAW, or DONE if the rectangle is empty.
  - DRAW: emits one pixel per cycle in raster order. `x` counts from x0' to x1'. At x1', `x` wraps to x0' and `y` increments. After the pixel (x1', y1'), next state is DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Clipping is applied at latch time:
  - x1' = min(x1, H_RES-1); y1' = min(y1, V_RES-1).
  - The rectangle is empty if x0 > x1', or y0 > y1', or x0 >= H_RES, or y0 >= V_RES. An empty rectangle goes straight to DONE with zero plots.
- Colour per pixel is combinational from the current counters and the latched config:
  - mode 0: colour_a
  - mode 1: colour_a if (x[CELL_LOG2] ^ y[CELL_LOG2]) == 0, else colour_b
  - mode 2: colour_a if y[CELL_LOG2] == 0, else colour_b
  - mode 3: colour_a if x[CELL_LOG2] == 0, else colour_b
- Pattern phase uses absolute screen coordinates, not offsets from x0/y0, so adjacent fills tile seamlessly.
- Input changes while not in IDLE have no effect; config is used only as latched.
- `start` while `busy`=1 or `done`=1 is ignored. It is not queued.
- Counter arithmetic is X_BITS/Y_BITS wide. Compare before incrementing so x = 2^X_BITS-1 never overflows.

## Timing

- Reset: on the next edge with `reset`=1 the state is IDLE, `plot`=0, `busy`=0, `done`=0, `x`=0, `y`=0, `colour`=0.
  - Reset mid-DRAW aborts the fill. No `done` is produced and no further `plot` is asserted after that edge.
- Outputs `x`, `y`, `colour` and `plot` are registered together, so `colour` always matches the `x`/`y` shown in the same cycle.
- Fill accepted on edge t (IDLE, `start`=1), with N = (x1'-x0+1)·(y1'-y0+1):
  - `plot`=1 and `busy`=1 on cycles t+1 … t+N
  - `done`=1 on cycle t+N+1
  - the next `start` is accepted at edge t+N+2
- Empty rectangle: `done`=1 on cycle t+1, with no plot cycles.
- A full 160x120 fill takes 19200 plot cycles plus 2 cycles of overhead.

## Test plan

- Reset then solid fill, mode 0, colour_a=3'b100, (0,0)-(159,119) -> exactly 19200 plots in raster order, first (0,0), last (159,119), all colour 4; `done` on cycle 19201.
- Checker fill, mode 1, a=3'b000, b=3'b111, (6,6)-(9,9) -> 16 plots; (7,7)=0; (8,7)=7; (8,8)=0; the x wrap from 9 back to 6 is seen at each row end.
- Clipping, (150,115)-(255,127) -> x runs 150..159 and y runs 115..119 (50 plots); no plot has x >= 160 or y >= 120.
- Empty rectangle x0=20, x1=10 -> zero plots; `done`=1 one cycle after `start`; `busy` never asserts.
- `start` re-pulsed and `colour_a` changed mid-DRAW -> ignored; the pixel count and colours match the original config.
- `reset` asserted on the 5th plot cycle of a fill -> from the next edge `plot`=0, `busy`=0, `done` never pulses; a new `start` after reset behaves normally.
